tetris_cmd_queue: RTL and testbench
===================================

# tetris_cmd_queue

Consumes the one-cycle press pulses from the per-key debouncers and the gravity timer and turns them into an ordered stream of game commands for the Tetris game FSM. Arbitrates simultaneous requests, buffers them in a small FIFO, and presents them through a valid/ready handshake. Also owns the pause toggle and the level-dependent gravity period.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- GRAVITY_BASE, 65000000: gravity period at Level 0, in Clk cycles (1 s at 65 MHz).
- GRAVITY_STEP, 4000000: period reduction per level.
- GRAVITY_MIN, 5000000: lower clamp on the period.

Ports:
- Clk  in  1  65 MHz system clock.
- Rst  in  1  synchronous, active-high reset.
- Key_Left, Key_Right, Key_Rotate, Key_Down, Key_Drop  in  1 each  one-cycle press pulses from the debouncers.
- Key_Pause  in  1  one-cycle pulse; toggles pause.
- Level  in  4  current game level, unsigned.
- Cmd_Valid  out  1  FIFO head holds a command.
- Cmd_Code  out  3  head command: 1 Left, 2 Right, 3 Rotate, 4 Down, 5 Drop, 6 Gravity; 0 when empty.
- Cmd_Ready  in  1  game FSM accepts the head this cycle.
- Paused  out  1  pause state.
- Overflow  out  1  one-cycle pulse when a key request is discarded.

## Operation
- Clocking: single Clk, no reset other than Rst. All state updates on posedge Clk.
- Gravity period: P = GRAVITY_BASE − Level×GRAVITY_STEP, computed at ≥32 bits, clamped to GRAVITY_MIN when the result is below GRAVITY_MIN or underflows. The counter is 27 bits.
- Gravity counter:
  - Increments each unpaused cycle.
  - When the counter is ≥ P−1: it resets to 0 and sets Gravity_Pending. The ≥ comparison makes a Level increase mid-count take effect immediately.
  - A tick while Gravity_Pending is already set is merged. It does not raise Overflow.
  - The counter resets to 0 in any cycle a user Down is enqueued.
- Arbitration: at most one push per cycle. Priority is Drop > Rotate > Left > Right > Down > Gravity_Pending.
  - Any key pulse that loses arbitration is discarded and pulses Overflow.
  - Gravity never discards; it stays pending until it wins.
- Push condition: the winner is pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - A key winner that cannot be pushed is discarded and pulses Overflow.
  - A gravity winner that cannot be pushed stays pending.
- FIFO: show-ahead. Cmd_Valid = not empty; Cmd_Code = head entry.
  - Pop when Cmd_Valid && Cmd_Ready.
  - Cmd_Ready while empty has no effect.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Pause:
  - Key_Pause toggles Paused.
  - On the cycle Paused rises: FIFO flushed (Cmd_Valid 0 next cycle), Gravity_Pending cleared, counter held.
  - While paused: key pulses other than Key_Pause are ignored (no Overflow), no pops, counter frozen.
  - On unpause, counting resumes from the held value.
  - A Key_Pause in the same cycle as other keys: the pause toggle is applied, and the other keys follow the rules for the new state.

## Timing
- Reset values: Cmd_Valid 0, Cmd_Code 0, Paused 0, Overflow 0; FIFO empty, counter 0, Gravity_Pending 0.
- Rst mid-operation discards all queued commands next cycle.
- Latency: a key pulse at edge N into an empty FIFO gives Cmd_Valid=1 with its code after edge N+1.
- Gravity: tick registered at edge N, pushed at N+1 if it wins, visible after N+1.
- Pop: head advances at the accepting edge. The next entry is visible the following cycle, with no bubble.
- Overflow is registered and asserts the cycle after the discarded pulse.

## Test plan
- Reset, then Key_Rotate pulse with Cmd_Ready=0 → Cmd_Valid=1, Cmd_Code=3 one cycle later; held until Cmd_Ready=1, then Cmd_Valid=0.
- Key_Left and Key_Drop in the same cycle, FIFO empty → only code 5 queued; Overflow pulses once.
- DEPTH=4, Cmd_Ready=0, five Key_Right pulses → four entries of code 2; fifth pulses Overflow. Pulse with Cmd_Ready=1 while full → accepted, still four entries.
- GRAVITY_BASE=100, STEP=10, MIN=20, Level=0 → code 6 every 100 cycles. Level=15 → period 20. Key_Down enqueued → next code 6 is 100 cycles after it.
- Three entries queued, Key_Pause → Paused=1, Cmd_Valid=0 next cycle; Key_Left while paused → no entry, no Overflow; counter frozen. Second Key_Pause → gravity resumes from the held count.
- Gravity tick in the same cycle as Key_Rotate with FIFO empty → code 3 first, code 6 next entry, no Overflow.

Source files
------------

// File: rtl/tetris_cmd_queue.sv
// tetris_cmd_queue
// Turns debounced key press pulses and the gravity timer into an ordered
// stream of game commands for the game FSM. Simultaneous requests are
// arbitrated (Drop > Rotate > Left > Right > Down > Gravity), buffered in a
// small show-ahead FIFO and offered through a valid/ready handshake. The block
// also owns the pause toggle and the level-dependent gravity period.
//
// Ports:
//   Clk         system clock (65 MHz)
//   Rst         synchronous, active-high reset
//   Key_Left, Key_Right, Key_Rotate, Key_Down, Key_Drop
//               one-cycle press pulses
//   Key_Pause   one-cycle pulse, toggles Paused
//   Level[3:0]  current game level
//   Cmd_Valid   FIFO head holds a command
//   Cmd_Code    head command (1 Left, 2 Right, 3 Rotate, 4 Down, 5 Drop,
//               6 Gravity), 0 when empty
//   Cmd_Ready   game FSM accepts the head this cycle
//   Paused      pause state
//   Overflow    one-cycle pulse, registered, when a key request is discarded
module tetris_cmd_queue #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned GRAVITY_BASE = 65000000,
   parameter int unsigned GRAVITY_STEP = 4000000,
   parameter int unsigned GRAVITY_MIN  = 5000000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Key_Left,
   input  logic       Key_Right,
   input  logic       Key_Rotate,
   input  logic       Key_Down,
   input  logic       Key_Drop,
   input  logic       Key_Pause,
   input  logic [3:0] Level,
   output logic       Cmd_Valid,
   output logic [2:0] Cmd_Code,
   input  logic       Cmd_Ready,
   output logic       Paused,
   output logic       Overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = 27;
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

   localparam logic [2:0] CMD_NONE   = 3'd0;
   localparam logic [2:0] CMD_LEFT   = 3'd1;
   localparam logic [2:0] CMD_RIGHT  = 3'd2;
   localparam logic [2:0] CMD_ROTATE = 3'd3;
   localparam logic [2:0] CMD_DOWN   = 3'd4;
   localparam logic [2:0] CMD_DROP   = 3'd5;
   localparam logic [2:0] CMD_GRAV   = 3'd6;

   // Gravity period for a level; an underflowing subtraction is detected
   // before it happens and clamps to the minimum like any too-small result.
   function automatic logic [31:0] gravity_period(input logic [3:0] lvl);
      logic [31:0] cut;
      logic [31:0] res;
      cut = {28'd0, lvl} * GRAVITY_STEP;
      if (cut >= GRAVITY_BASE) begin
         res = GRAVITY_MIN;
      end else if ((GRAVITY_BASE - cut) < GRAVITY_MIN) begin
         res = GRAVITY_MIN;
      end else begin
         res = GRAVITY_BASE - cut;
      end
      return res;
   endfunction

   // State
   logic [2:0]    mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] cnt_r;
   logic          grav_pend_r;
   logic          paused_r;
   logic          valid_r;
   logic [2:0]    code_r;
   logic          overflow_r;

   // Combinational decode
   logic          paused_nxt_s;
   logic          pause_rise_s;
   logic          active_s;
   logic [4:0]    keys_s;
   logic          lose_s;
   logic          win_key_s;
   logic [2:0]    win_code_s;
   logic [PW-1:0] count_s;
   logic          full_s;
   logic          pop_s;
   logic          push_s;
   logic          ovf_s;
   logic [31:0]   period_s;
   logic [31:0]   per_m1_s;
   logic          tick_s;
   logic [CW-1:0] cnt_nxt_s;
   logic          pend_nxt_s;
   logic [PW-1:0] wr_nxt_s;
   logic [PW-1:0] rd_nxt_s;
   logic          valid_nxt_s;
   logic [2:0]    code_nxt_s;

   // Pause toggle decode; keys in the toggle cycle obey the new state.
   always_comb begin
      paused_nxt_s = paused_r ^ Key_Pause;
      pause_rise_s = ~paused_r & Key_Pause;
      active_s     = ~paused_nxt_s;
   end

   // Fixed-priority arbitration between key pulses and pending gravity.
   always_comb begin
      keys_s     = active_s ? {Key_Drop, Key_Rotate, Key_Left, Key_Right, Key_Down} : 5'd0;
      // More than one bit set means at least one key loses.
      lose_s     = (keys_s & (keys_s - 5'd1)) != 5'd0;
      win_key_s  = keys_s != 5'd0;
      win_code_s = CMD_NONE;
      casez (keys_s)
         5'b1????: win_code_s = CMD_DROP;
         5'b01???: win_code_s = CMD_ROTATE;
         5'b001??: win_code_s = CMD_LEFT;
         5'b0001?: win_code_s = CMD_RIGHT;
         5'b00001: win_code_s = CMD_DOWN;
         default:  win_code_s = (grav_pend_r && active_s) ? CMD_GRAV : CMD_NONE;
      endcase
   end

   // FIFO push/pop qualification and overflow detection.
   always_comb begin
      count_s = wr_ptr_r - rd_ptr_r;
      full_s  = count_s == FULL_CNT;
      pop_s   = valid_r & Cmd_Ready & active_s;
      // A full FIFO still accepts when the head leaves in the same cycle.
      push_s  = (win_code_s != CMD_NONE) && (!full_s || pop_s);
      ovf_s   = lose_s | (win_key_s & ~push_s);
   end

   // Gravity counter and pending flag.
   always_comb begin
      period_s   = gravity_period(Level);
      per_m1_s   = (period_s == 32'd0) ? 32'd0 : period_s - 32'd1;
      tick_s     = 1'b0;
      cnt_nxt_s  = cnt_r;
      pend_nxt_s = grav_pend_r;
      if (pause_rise_s) begin
         pend_nxt_s = 1'b0;
      end else if (active_s) begin
         // >= rather than == so a level increase mid-count fires at once.
         tick_s = {5'd0, cnt_r} >= per_m1_s;
         if (tick_s || (push_s && (win_code_s == CMD_DOWN))) begin
            cnt_nxt_s = {CW{1'b0}};
         end else begin
            cnt_nxt_s = cnt_r + 27'd1;
         end
         pend_nxt_s = (grav_pend_r & ~(push_s && (win_code_s == CMD_GRAV))) | tick_s;
      end else begin
         cnt_nxt_s  = cnt_r;
         pend_nxt_s = grav_pend_r;
      end
   end

   // Next pointers and next registered head (with write bypass).
   always_comb begin
      if (pause_rise_s) begin
         wr_nxt_s = {PW{1'b0}};
         rd_nxt_s = {PW{1'b0}};
      end else begin
         wr_nxt_s = wr_ptr_r + {{(PW-1){1'b0}}, push_s};
         rd_nxt_s = rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
      end
      valid_nxt_s = wr_nxt_s != rd_nxt_s;
      if (!valid_nxt_s) begin
         code_nxt_s = CMD_NONE;
      end else if (push_s && (rd_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
         // New head is the slot being written this cycle.
         code_nxt_s = win_code_s;
      end else begin
         code_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
      end
   end

   // FIFO storage write port.
   always_ff @(posedge Clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= win_code_s;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         grav_pend_r <= 1'b0;
         paused_r    <= 1'b0;
         valid_r     <= 1'b0;
         code_r      <= CMD_NONE;
         overflow_r  <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_nxt_s;
         rd_ptr_r    <= rd_nxt_s;
         cnt_r       <= cnt_nxt_s;
         grav_pend_r <= pend_nxt_s;
         paused_r    <= paused_nxt_s;
         valid_r     <= valid_nxt_s;
         code_r      <= code_nxt_s;
         overflow_r  <= ovf_s;
      end
   end

   assign Cmd_Valid = valid_r;
   assign Cmd_Code  = code_r;
   assign Paused    = paused_r;
   assign Overflow  = overflow_r;

endmodule

// File: tb/tb_tetris_cmd_queue.sv
// Randomized self-checking bench for tetris_cmd_queue with a queue-based
// behavioural reference model. Small gravity parameters keep periods short.
module tb_tetris_cmd_queue;

   localparam int DEPTH = 4;
   localparam int GB    = 100;
   localparam int GS    = 10;
   localparam int GM    = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       k_left, k_right, k_rotate, k_down, k_drop, k_pause;
   logic [3:0] level;
   logic       valid;
   logic [2:0] code;
   logic       ready;
   logic       paused;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   int m_q[$];
   bit m_paused;
   bit m_pend;
   bit m_ovf;
   int m_cnt;

   tetris_cmd_queue #(
      .DEPTH(DEPTH), .GRAVITY_BASE(GB), .GRAVITY_STEP(GS), .GRAVITY_MIN(GM)
   ) dut (
      .Clk(clk), .Rst(rst),
      .Key_Left(k_left), .Key_Right(k_right), .Key_Rotate(k_rotate),
      .Key_Down(k_down), .Key_Drop(k_drop), .Key_Pause(k_pause),
      .Level(level),
      .Cmd_Valid(valid), .Cmd_Code(code), .Cmd_Ready(ready),
      .Paused(paused), .Overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
      end
   endtask

   // One clock of the game-command rules applied to the model.
   task automatic model_step();
      int  reqs[$];
      int  p;
      bit  tick;
      bit  popped;
      bit  can;
      bit  grav_push;
      int  win;
      if (rst) begin
         m_q.delete();
         m_paused = 0; m_pend = 0; m_ovf = 0; m_cnt = 0;
         return;
      end
      if (k_pause && !m_paused) begin
         m_paused = 1; m_q.delete(); m_pend = 0; m_ovf = 0;
         return;
      end
      if (k_pause) m_paused = 0;
      if (m_paused) begin
         m_ovf = 0;
         return;
      end
      if (k_drop)   reqs.push_back(5);
      if (k_rotate) reqs.push_back(3);
      if (k_left)   reqs.push_back(1);
      if (k_right)  reqs.push_back(2);
      if (k_down)   reqs.push_back(4);
      popped = (m_q.size() > 0) && ready;
      can    = (m_q.size() < DEPTH) || popped;
      p = GB - int'(level) * GS;
      if (p < GM) p = GM;
      tick = (m_cnt >= p - 1);
      if (popped) void'(m_q.pop_front());
      m_ovf = (reqs.size() > 1) || (reqs.size() > 0 && !can);
      grav_push = 0;
      win = 0;
      if (reqs.size() > 0) begin
         if (can) begin
            m_q.push_back(reqs[0]);
            win = reqs[0];
         end
      end else if (m_pend && can) begin
         m_q.push_back(6);
         grav_push = 1;
      end
      if (win == 4 || tick) m_cnt = 0;
      else m_cnt++;
      m_pend = (m_pend && !grav_push) || tick;
   endtask

   task automatic check_outputs();
      check_eq("valid", int'(valid), (m_q.size() > 0) ? 1 : 0);
      check_eq("code", int'(code), (m_q.size() > 0) ? m_q[0] : 0);
      check_eq("paused", int'(paused), int'(m_paused));
      check_eq("overflow", int'(overflow), int'(m_ovf));
   endtask

   function automatic logic pick(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   // Phase table: length, key %, ready %, pause %, level (-1 = random)
   int ph_len  [6] = '{40, 320, 120, 400, 400, 300};
   int ph_key  [6] = '{30,   0,   0,  10,  25,  15};
   int ph_rdy  [6] = '{ 0, 100,  50,  50,  30,  60};
   int ph_pau  [6] = '{ 0,   0,   0,   2,   3,   2};
   int ph_lvl  [6] = '{ 0,   0,  15,  -1,  -1,  -1};

   initial begin
      rst = 1'b1;
      {k_left, k_right, k_rotate, k_down, k_drop, k_pause} = 6'd0;
      ready = 1'b0;
      level = 4'd0;
      repeat (2) begin
         @(posedge clk);
         model_step();
      end
      @(negedge clk);
      cyc++;
      check_outputs();
      rst = 1'b0;
      for (int ph = 0; ph < 6; ph++) begin
         if (ph_lvl[ph] >= 0) level = 4'(ph_lvl[ph]);
         // Mid-run reset with stray key activity before the last phase.
         if (ph == 5) begin
            rst = 1'b1;
            k_drop = 1'b1;
            ready = 1'b1;
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            check_outputs();
            rst = 1'b0;
         end
         for (int i = 0; i < ph_len[ph]; i++) begin
            k_left   = pick(ph_key[ph]);
            k_right  = pick(ph_key[ph]);
            k_rotate = pick(ph_key[ph]);
            k_down   = pick(ph_key[ph]);
            k_drop   = pick(ph_key[ph]);
            k_pause  = pick(ph_pau[ph]);
            ready    = pick(ph_rdy[ph]);
            if (ph_lvl[ph] < 0 && pick(5)) level = 4'($urandom_range(15));
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            check_outputs();
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
